// File: rtl/dec_pkg.sv
// Shared constants, FIFO occupancy state and entry metadata for dec3to8_stream.
package dec_pkg;

    localparam int unsigned CODE_W   = 3;
    localparam int unsigned ONEHOT_W = 8;
    localparam int unsigned CNT_W    = 16;

    // Occupancy of the two-entry output buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    // Per-entry record kept alongside each word for the round-trip check
    typedef struct packed {
        logic              en;
        logic [CODE_W-1:0] code;
    } entry_meta_t;

    // Binary index to one-hot word; a cleared enable gives an all-zero word
    function automatic logic [ONEHOT_W-1:0] decode_word(
        input logic [CODE_W-1:0] code,
        input logic              en
    );
        logic [ONEHOT_W-1:0] word;
        word = ONEHOT_W'(1) << code;
        return en ? word : '0;
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary re-encoder: lowest set bit wins, zero flag when no bit is set.
module onehot_to_bin
    import dec_pkg::*;
(
    input  logic [ONEHOT_W-1:0] onehot,
    output logic [CODE_W-1:0]   idx,
    output logic                zero
);

    // Scan from the top down so the lowest set bit is written last
    always_comb begin
        idx  = '0;
        zero = 1'b1;
        for (int i = ONEHOT_W - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                idx  = CODE_W'(i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dec3to8_stream.sv
// 3-to-8 decoder feeding a two-entry ready/valid output buffer with a
// transfer counter. Optional round-trip self-check under DEC3TO8_RTCHECK_EN.
module dec3to8_stream
    import dec_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   in_code,
    input  logic                in_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ONEHOT_W-1:0] out_onehot,
    output logic [CNT_W-1:0]    beat_cnt,
    output logic                chk_err
);

    fifo_state_t         state_q, state_d;
    logic [ONEHOT_W-1:0] head_q, head_d;
    logic [ONEHOT_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [ONEHOT_W-1:0] new_word;
    logic                push;
    logic                pop;

    assign new_word   = decode_word(in_code, in_en);
    // FULL never accepts, even when the head leaves in the same cycle
    assign push       = in_valid && (state_q != FULL);
    assign pop        = out_ready && (state_q != EMPTY);

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_onehot = head_q;
    assign beat_cnt   = cnt_q;

    // Buffer occupancy, word movement and transfer counting
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = new_word;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_word;
                end else if (push) begin
                    tail_d  = new_word;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // State, data and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef DEC3TO8_RTCHECK_EN
    entry_meta_t         head_meta_q, head_meta_d;
    entry_meta_t         tail_meta_q, tail_meta_d;
    entry_meta_t         new_meta;
    logic [CODE_W-1:0]   enc_idx;
    logic                enc_zero;
    logic                multi_hot;
    logic                rt_fail;
    logic                err_q;

    assign new_meta = '{en: in_en, code: in_code};

    onehot_to_bin u_enc (
        .onehot (head_q),
        .idx    (enc_idx),
        .zero   (enc_zero)
    );

    assign multi_hot = |(head_q & (head_q - ONEHOT_W'(1)));
    assign rt_fail   = pop && ((!enc_zero && (enc_idx != head_meta_q.code)) ||
                               (head_meta_q.en && (enc_zero || multi_hot)));
    assign chk_err   = err_q;

    // Metadata follows its word through the buffer
    always_comb begin
        head_meta_d = head_meta_q;
        tail_meta_d = tail_meta_q;
        case (state_q)
            EMPTY: if (push) head_meta_d = new_meta;
            ONE: begin
                if (push && pop) begin
                    head_meta_d = new_meta;
                end else if (push) begin
                    tail_meta_d = new_meta;
                end
            end
            FULL: if (pop) head_meta_d = tail_meta_q;
            default: head_meta_d = head_meta_q;
        endcase
    end

    // Metadata registers and sticky mismatch flag
    always_ff @(posedge clk) begin
        if (rst) begin
            head_meta_q <= '0;
            tail_meta_q <= '0;
            err_q       <= 1'b0;
        end else begin
            head_meta_q <= head_meta_d;
            tail_meta_q <= tail_meta_d;
            if (rt_fail) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_dec3to8_stream.sv
// Self-checking bench for dec3to8_stream: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_dec3to8_stream;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_code;
    logic        in_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_onehot;
    logic [15:0] beat_cnt;
    logic        chk_err;

    int total = 0;
    int bad   = 0;

    // Reference model: words waiting in order, words delivered, transfer count
    logic [7:0]  mq[$];
    logic [7:0]  popped[$];
    logic [15:0] exp_cnt;

    dec3to8_stream dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .beat_cnt   (beat_cnt),
        .chk_err    (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs on the falling edge, away from the sampling edge
    task automatic drive(input logic r, input logic iv, input int code,
                         input logic en, input logic ordy);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_code   = 3'(code);
        in_en     = en;
        out_ready = ordy;
    endtask

    // Clock one edge and advance the model with the applied inputs
    task automatic advance();
        logic       acc;
        logic       pop;
        logic [7:0] w;
        acc = !rst && in_valid && (mq.size() < 2);
        pop = !rst && out_ready && (mq.size() > 0);
        w   = in_en ? 8'(2 ** int'(in_code)) : 8'h00;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_cnt = 16'd0;
        end else begin
            if (pop) begin
                popped.push_back(mq.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            if (acc) mq.push_back(w);
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        advance();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        popped.delete();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 3, 1'b1, 1'b1);
        advance();
        advance();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (beat_cnt !== 16'd0) begin bad++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
        total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL reset_chk_err got=%b exp=0", chk_err); end
        total++; if (out_onehot !== 8'h00) begin bad++; $display("FAIL reset_onehot got=%h exp=00", out_onehot); end
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b0, 1'b1, 5, 1'b1, 1'b1);
        advance();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_onehot !== 8'h20) begin bad++; $display("FAIL single_onehot got=%h exp=20", out_onehot); end
        advance();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        total++; if (beat_cnt !== 16'd1) begin bad++; $display("FAIL single_beat got=%0d exp=1", beat_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_disable();
        do_reset();
        drive(1'b0, 1'b1, 7, 1'b0, 1'b0);
        advance();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL disable_valid got=%b exp=1", out_valid); end
        total++; if (out_onehot !== 8'h00) begin bad++; $display("FAIL disable_onehot got=%h exp=00", out_onehot); end
        advance();
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_seq[3];
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h04;
        do_reset();
        drive(1'b0, 1'b1, 0, 1'b1, 1'b0); advance();
        drive(1'b0, 1'b1, 1, 1'b1, 1'b0); advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2, 1'b1, 1'b0);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready cyc=%0d got=%b exp=0", i, in_ready); end
            total++; if (out_onehot !== 8'h01) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h exp=01", i, out_onehot); end
            advance();
        end
        // Pop while FULL: code 2 still offered but must not enter
        drive(1'b0, 1'b1, 2, 1'b1, 1'b1); advance();
        drive(1'b0, 1'b1, 2, 1'b1, 1'b0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_pop_ready got=%b exp=1", in_ready); end
        total++; if (out_onehot !== 8'h02) begin bad++; $display("FAIL bp_after_pop_head got=%h exp=02", out_onehot); end
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
            if (out_valid) begin
                total++; if (out_onehot !== mq[0]) begin bad++; $display("FAIL bp_drain cyc=%0d got=%h exp=%h", i, out_onehot, mq[0]); end
            end
            advance();
        end
        total++; if (popped.size() != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", popped.size()); end
        for (int i = 0; i < 3 && i < popped.size(); i++) begin
            total++; if (popped[i] !== exp_seq[i]) begin bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, popped[i], exp_seq[i]); end
        end
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        total++; if (beat_cnt !== exp_cnt) begin bad++; $display("FAIL bp_beat got=%0d exp=%0d", beat_cnt, exp_cnt); end
    endtask

    task automatic test_stream();
        do_reset();
        drive(1'b0, 1'b1, 0, 1'b1, 1'b1); advance();
        for (int c = 1; c < 8; c++) begin
            drive(1'b0, 1'b1, c, 1'b1, 1'b1);
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL stream_one cyc=%0d valid=%b ready=%b exp=1,1", c, out_valid, in_ready); end
            total++; if (out_onehot !== mq[0]) begin bad++; $display("FAIL stream_word cyc=%0d got=%h exp=%h", c, out_onehot, mq[0]); end
            advance();
        end
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1); advance();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        total++; if (beat_cnt !== 16'd8) begin bad++; $display("FAIL stream_beat got=%0d exp=8", beat_cnt); end
        for (int i = 0; i < popped.size(); i++) begin
            total++; if (popped[i] !== 8'(2 ** i)) begin bad++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, popped[i], 8'(2 ** i)); end
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        drive(1'b0, 1'b1, 4, 1'b1, 1'b0); advance();
        drive(1'b0, 1'b1, 6, 1'b1, 1'b0); advance();
        drive(1'b1, 1'b1, 3, 1'b1, 1'b1); advance();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstfull_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstfull_ready got=%b exp=1", in_ready); end
        total++; if (beat_cnt !== 16'd0) begin bad++; $display("FAIL rstfull_beat got=%0d exp=0", beat_cnt); end
        for (int i = 0; i < 3; i++) begin
            advance();
            drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
            total++; if (out_valid !== 1'b0 || beat_cnt !== 16'd0) begin bad++; $display("FAIL rstfull_stale cyc=%0d valid=%b beat=%0d exp=0,0", i, out_valid, beat_cnt); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), 1'($urandom), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), 1'($urandom));
            total++; if (in_ready !== (mq.size() < 2)) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, in_ready, mq.size() < 2); end
            total++; if (out_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, out_valid, mq.size() > 0); end
            if (mq.size() > 0) begin
                total++; if (out_onehot !== mq[0]) begin bad++; $display("FAIL rand_word cyc=%0d got=%h exp=%h", i, out_onehot, mq[0]); end
            end
            total++; if (beat_cnt !== exp_cnt) begin bad++; $display("FAIL rand_beat cyc=%0d got=%0d exp=%0d", i, beat_cnt, exp_cnt); end
            total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL rand_chk_err cyc=%0d got=%b exp=0", i, chk_err); end
            advance();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            drive(1'b0, 1'b1, i % 8, 1'b1, 1'b1);
            if ((i % 8192) == 0) begin
                total++; if (beat_cnt !== exp_cnt) begin bad++; $display("FAIL wrap_mid cyc=%0d got=%0d exp=%0d", i, beat_cnt, exp_cnt); end
                total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL wrap_chk_err cyc=%0d got=%b exp=0", i, chk_err); end
            end
            advance();
            popped.delete();
        end
        drive(1'b0, 1'b0, 0, 1'b0, 1'b1); advance();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        total++; if (beat_cnt !== 16'd0) begin bad++; $display("FAIL wrap_beat got=%0d exp=0", beat_cnt); end
        total++; if (beat_cnt !== exp_cnt) begin bad++; $display("FAIL wrap_model got=%0d exp=%0d", beat_cnt, exp_cnt); end
        total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL wrap_chk_err_end got=%b exp=0", chk_err); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        in_en     = 1'b0;
        out_ready = 1'b0;
        exp_cnt   = 16'd0;
        test_reset();
        test_single();
        test_disable();
        test_backpressure();
        test_stream();
        test_reset_full();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
